elastic_pipe_chain: RTL and testbench

- Parametrised N-stage pipeline register chain with a per-stage valid bit, ready backpressure, bubble collapsing, range flush and global hold.
- Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latch pairs of the 5-stage core into one configurable block.
- Used by the next core generation to carry instruction payloads between pipeline stages.
- Stage 0 is the youngest (input side); stage STAGES-1 is the oldest and drives the output.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_slot.sv | 38 +++
 rtl/elastic_pipe_chain.sv | 105 ++++++++++
 tb/tb_elastic_pipe_chain.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline chain.
package pipe_pkg;

  localparam int PIPE_STAGES_DEF = 5;
  localparam int PIPE_WIDTH_DEF  = 32;
  localparam int PIPE_STAGES_MAX = 16;

  function automatic logic [4:0] popcount(input logic [PIPE_STAGES_MAX-1:0] bits);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < PIPE_STAGES_MAX; i++) begin
      n = n + {4'b0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage: a valid bit plus a payload register.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             kill,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  // NOTE: sequential state is written with <= so every stage samples its
  // neighbour's pre-edge value; blocking here would ripple data in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
    end else if (kill) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
    end
  end

  // Killed stages keep their stale payload; only the valid bit matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data <= '0;
    end else if (load && !kill) begin
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/elastic_pipe_chain.sv
// N-stage elastic register chain with ready backpressure, bubble collapsing,
// range flush and global hold. Stage 0 is youngest, stage STAGES-1 drives out.
module elastic_pipe_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = PIPE_STAGES_DEF,
  parameter int WIDTH  = PIPE_WIDTH_DEF,
  parameter int CNT_W  = $clog2(STAGES + 1),
  parameter int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  input  logic [IDX_W-1:0] flush_upto,
  output logic [CNT_W-1:0] occupancy
);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  data [STAGES];
  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] d_valid;
  logic [STAGES-1:0] nv;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    rdy      = '0;
    load     = '0;
    kill     = '0;
    d_valid  = '0;
    nv       = '0;
    in_ready = 1'b0;

    // A stage can take new content if it is empty or its successor moves.
    rdy[STAGES] = out_ready & ~hold;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
    in_ready = rdy[0] & ~hold;

    for (int i = 0; i < STAGES; i++) begin
      kill[i] = flush & (i <= int'(flush_upto));
      load[i] = rdy[i] & ~hold;
    end

    // The stage just above a flushed range receives a bubble.
    d_valid[0] = in_valid & in_ready;
    for (int i = 1; i < STAGES; i++) begin
      d_valid[i] = v[i-1] & ~kill[i-1];
    end

    for (int i = 0; i < STAGES; i++) begin
      if (kill[i]) begin
        nv[i] = 1'b0;
      end else if (load[i]) begin
        nv[i] = d_valid[i];
      end else begin
        nv[i] = v[i];
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] d_data;

    if (g == 0) begin : g_head
      assign d_data = in_data;
    end else begin : g_body
      assign d_data = data[g-1];
    end

    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[g]),
      .kill    (kill[g]),
      .d_valid (d_valid[g]),
      .d_data  (d_data),
      .q_valid (v[g]),
      .q_data  (data[g])
    );
  end

  assign out_valid = v[STAGES-1] & ~hold;
  assign out_data  = data[STAGES-1];

  // Counting next-state valids keeps occupancy aligned with v after each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      occupancy <= CNT_W'(popcount(PIPE_STAGES_MAX'(nv)));
    end
  end

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed scoreboard bench for elastic_pipe_chain with STAGES=5, WIDTH=32.
module tb_elastic_pipe_chain;

  localparam int STAGES = 5;
  localparam int WIDTH  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             hold = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       flush_upto = '0;
  logic [2:0]       occupancy;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int accepts = 0;
  int edges = 0;
  logic [31:0] q[$];

  elastic_pipe_chain #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .hold       (hold),
    .flush      (flush),
    .flush_upto (flush_upto),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step: pop/compare on output transfer, push on accepted input.
  task automatic step();
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("out_unexpected", {31'b0, out_valid}, 32'd0);
      end else begin
        check("out_data", out_data, q[0]);
        void'(q.pop_front());
        pops++;
      end
    end
    if (in_valid && in_ready && !flush) begin
      q.push_back(in_data);
      accepts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < budget && q.size() != 0; n++) step();
    check("drain_empty", q.size(), 32'd0);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("drain_occupancy", {29'b0, occupancy}, 32'd0);
  endtask

  task automatic fill(input logic [31:0] base);
    out_ready = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      in_valid = 1'b1;
      in_data  = base + k;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_occupancy", {29'b0, occupancy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Streaming: first output on the 5th edge, then one per cycle
    out_ready = 1'b1;
    pops = 0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = k;
      step();
      if (k == 4) check("stream_not_yet", {31'b0, out_valid}, 32'd0);
      if (k == 5) begin
        check("stream_first_valid", {31'b0, out_valid}, 32'd1);
        check("stream_first_data", out_data, 32'h1);
        check("stream_occ_peak", {29'b0, occupancy}, 32'd5);
      end
    end
    drain(20);
    check("stream_pops", pops, 32'd8);

    // Backpressure fill
    out_ready = 1'b0;
    pops = 0;
    accepts = 0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + k;
      step();
    end
    in_valid = 1'b0;
    check("bp_accepts", accepts, 32'd5);
    check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    check("bp_occupancy", {29'b0, occupancy}, 32'd5);
    check("bp_out_data", out_data, 32'hA0);
    step();
    check("bp_out_stable", out_data, 32'hA0);
    drain(20);
    check("bp_pops", pops, 32'd5);

    // Bubble collapse
    out_ready = 1'b0;
    pops = 0;
    in_valid = 1'b1; in_data = 32'h11; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 32'h22; step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("bubble_occupancy", {29'b0, occupancy}, 32'd2);
    check("bubble_out_data", out_data, 32'h11);
    drain(20);
    check("bubble_pops", pops, 32'd2);

    // Partial flush of stages 0..2
    pops = 0;
    fill(32'hB0);
    check("pflush_full", {29'b0, occupancy}, 32'd5);
    flush = 1'b1;
    flush_upto = 3'd2;
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) void'(q.pop_back());
    check("pflush_occupancy", {29'b0, occupancy}, 32'd2);
    check("pflush_out_data", out_data, 32'hB0);
    drain(20);
    check("pflush_pops", pops, 32'd2);

    // Hold plus flush of stage 0
    pops = 0;
    fill(32'hC0);
    hold = 1'b1;
    flush = 1'b1;
    flush_upto = 3'd0;
    out_ready = 1'b1;
    #1;
    check("hold_out_valid", {31'b0, out_valid}, 32'd0);
    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
    step();
    void'(q.pop_back());
    flush = 1'b0;
    check("holdflush_occupancy", {29'b0, occupancy}, 32'd4);
    check("holdflush_out_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("hold_occupancy", {29'b0, occupancy}, 32'd4);
    check("hold_out_data", out_data, 32'hC0);
    hold = 1'b0;
    drain(20);
    check("hold_pops", pops, 32'd4);

    // Async reset mid-stream, then single-item latency
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hD0 + k;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_occupancy", {29'b0, occupancy}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    pops = 0;
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      step();
      edges++;
    end
    check("arst_latency_edges", edges, 32'd5);
    check("arst_out_data", out_data, 32'h55);
    check("arst_occ_one", {29'b0, occupancy}, 32'd1);
    drain(10);
    check("arst_pops", pops, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
